sprite_palette_lut: RTL and testbench
=====================================

Name: sprite_palette_lut

Overview:
Parametrised, writable, multi-bank sprite colour lookup. Maps a per-pixel palette index to 12-bit RGB through a one-cycle registered pipeline, and flags the transparency key index. Holds NUM_PAL banks: the bank is chosen at frame boundaries and banks are rewritable at run time (colour swaps, alternate player skins). Sits between the sprite ROM index fetch and the VGA colour mux.

Parameters:
INDEX_W, 4, palette index width; each bank holds 2**INDEX_W entries
PAL_SEL_W, 2, bank select width; NUM_PAL = 2**PAL_SEL_W
COLOR_W, 4, bits per colour channel
TRANSP_INDEX, 1, index treated as transparent (magenta key)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous reset, active-low
pix_valid_i  in  1  pixel index valid this cycle
pix_index_i  in  INDEX_W  palette index
frame_start_i  in  1  one-cycle pulse at first pixel of frame
pal_sel_i  in  PAL_SEL_W  requested bank, sampled only on frame_start_i
wr_en_i  in  1  palette entry write strobe
wr_pal_i  in  PAL_SEL_W  bank to write
wr_index_i  in  INDEX_W  entry to write
wr_rgb_i  in  3*COLOR_W  {r,g,b} write data
pix_valid_o  out  1  output pixel valid
red_o, green_o, blue_o  out  COLOR_W each  looked-up colour
transparent_o  out  1  pixel is the transparency key
active_pal_o  out  PAL_SEL_W  bank currently in use

Behaviour:
- Reset (Reset_n low at a Clk edge): every entry of every bank loads DEFAULT_PALETTE. active_pal_o=0. pix_valid_o=0. RGB outputs=0. transparent_o=0. Reset mid-frame discards in-flight pixels. Pending writes in the reset cycle are dropped.
- Bank select: effective bank = frame_start_i ? pal_sel_i : active_pal. The pixel presented with frame_start_i uses the new bank. active_pal_o updates at that edge. pal_sel_i changes between frame_start_i pulses have no effect.
- Lookup latency: 1 cycle. pix_valid_o = pix_valid_i delayed by one cycle.
- When pix_valid_o=1, RGB outputs show the registered colour of the entry at the effective bank and pix_index_i from the previous cycle.
- When pix_valid_o=0, RGB outputs=0 and transparent_o=0. This gives blanking-safe output.
- transparent_o = registered (pix_valid_i && pix_index_i==TRANSP_INDEX). It depends on the index only, not on the colour content.
- Write: when wr_en_i=1, the entry (wr_pal_i, wr_index_i) takes wr_rgb_i at the edge.
- Write-first forwarding: a lookup in the same cycle that hits the same bank and index outputs wr_rgb_i.
- Writes to an inactive bank never disturb output.
- Indices wrap naturally; there is no out-of-range case.
- Back-to-back pixels are supported at full rate with no stalls.

Optional Feature:
Macro PAL_FADE_EN.
- Defined: adds input fade_i (COLOR_W) and a second register stage. Each channel = saturating (channel − fade_i), clamped at 0. Latency becomes 2, and pix_valid_o and transparent_o are delayed to match. fade_i is sampled with the pixel.
- Undefined: the fade_i port is absent and latency is 1.

Decomposition:
- Package sprite_palette_pkg holds:
  - rgb_t packed struct {r,g,b} of COLOR_W each.
  - DEFAULT_PALETTE: 16 entries 12'h814,F0F,ECA,115,C1A,B75,A01,621,229,A18,002,425,E1D,843,D33,D97, replicated or truncated to 2**INDEX_W.
  - Default TRANSP_INDEX.
- One sub-module, palette_bank_ram: a single bank's register array with reset-load, a write port and a combinational read with write-first bypass. It is instantiated NUM_PAL times, and the top muxes across banks by effective bank.

Test Plan:
- Reset, then index 0 valid → next cycle RGB=8,1,4, pix_valid_o=1, transparent_o=0. Index 1 → F,0,F with transparent_o=1.
- Write bank 2 index 3 = 12'h0F0, pal_sel_i=2 with frame_start_i alongside index 3 → output 0,F,0 one cycle later, active_pal_o=2. Next pixel index 3 → still 0,F,0.
- pal_sel_i changes to 1 mid-frame without frame_start_i → active_pal_o and colours unchanged until the next frame_start_i.
- Same-cycle write of bank 0 index 5 = 12'h123 and lookup of index 5 → output 1,2,3 (forwarded). The following lookup of the same entry also gives 1,2,3.
- pix_valid_i toggling 1,0,1 → pix_valid_o 0,1,0,1 with RGB=0 during invalid cycles. Reset_n low mid-stream → the next cycle has all outputs 0 and entries restored to defaults.
- With PAL_FADE_EN, fade_i=4 on index 2 (E,C,A) → after 2 cycles A,8,6. fade_i=F → 0,0,0.

Source files
------------

// File: rtl/sprite_palette_pkg.sv
// Shared types and reset contents for the sprite palette lookup.
// Default 16-entry colour table, replicated to fill larger banks.
package sprite_palette_pkg;

  localparam int unsigned COLOR_W_DEF      = 4;
  localparam int unsigned TRANSP_INDEX_DEF = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t default_entry(input logic [3:0] idx);
    rgb_t c;
    case (idx)
      4'd0:    c = 12'h814;
      4'd1:    c = 12'hF0F;
      4'd2:    c = 12'hECA;
      4'd3:    c = 12'h115;
      4'd4:    c = 12'hC1A;
      4'd5:    c = 12'hB75;
      4'd6:    c = 12'hA01;
      4'd7:    c = 12'h621;
      4'd8:    c = 12'h229;
      4'd9:    c = 12'hA18;
      4'd10:   c = 12'h002;
      4'd11:   c = 12'h425;
      4'd12:   c = 12'hE1D;
      4'd13:   c = 12'h843;
      4'd14:   c = 12'hD33;
      default: c = 12'hD97;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/palette_bank_ram.sv
// One palette bank: register array loaded with the default table on reset,
// single write port, combinational read with write-first bypass.
module palette_bank_ram
  import sprite_palette_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned COLOR_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [INDEX_W-1:0]     i_wr_index,
  input  logic [3*COLOR_W-1:0]   i_wr_rgb,
  input  logic [INDEX_W-1:0]     i_rd_index,
  output logic [3*COLOR_W-1:0]   o_rd_rgb
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam int unsigned RGB_W = 3 * COLOR_W;

  logic [RGB_W-1:0] r_mem [DEPTH];

  // Default nibbles are MSB-aligned into wider channels
  function automatic logic [COLOR_W-1:0] widen(input logic [3:0] nib);
    logic [COLOR_W-1:0] w;
    w = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b < COLOR_W) w[COLOR_W-1-b] = nib[3-b];
    end
    return w;
  endfunction

  function automatic logic [RGB_W-1:0] reset_value(input int unsigned idx);
    rgb_t d;
    d = default_entry(4'(idx));
    return {widen(d.r), widen(d.g), widen(d.b)};
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= reset_value(i);
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_index] <= i_wr_rgb;
    end
  end

  always_comb begin
    o_rd_rgb = r_mem[i_rd_index];
    if (i_wr_en && (i_wr_index == i_rd_index)) o_rd_rgb = i_wr_rgb;
  end

endmodule

// File: rtl/sprite_palette_lut.sv
// Multi-bank sprite palette lookup, index -> registered 12-bit RGB plus key flag.
// Optional PAL_FADE_EN adds fade_i and a saturating-subtract second stage.
module sprite_palette_lut
  import sprite_palette_pkg::*;
#(
  parameter int unsigned INDEX_W      = 4,
  parameter int unsigned PAL_SEL_W    = 2,
  parameter int unsigned COLOR_W      = COLOR_W_DEF,
  parameter int unsigned TRANSP_INDEX = TRANSP_INDEX_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 pix_valid_i,
  input  logic [INDEX_W-1:0]   pix_index_i,
  input  logic                 frame_start_i,
  input  logic [PAL_SEL_W-1:0] pal_sel_i,
  input  logic                 wr_en_i,
  input  logic [PAL_SEL_W-1:0] wr_pal_i,
  input  logic [INDEX_W-1:0]   wr_index_i,
  input  logic [3*COLOR_W-1:0] wr_rgb_i,
  output logic                 pix_valid_o,
  output logic [COLOR_W-1:0]   red_o,
  output logic [COLOR_W-1:0]   green_o,
  output logic [COLOR_W-1:0]   blue_o,
  output logic                 transparent_o,
  output logic [PAL_SEL_W-1:0] active_pal_o
`ifdef PAL_FADE_EN
  ,
  input  logic [COLOR_W-1:0]   fade_i
`endif
);

  localparam int unsigned NUM_PAL = 1 << PAL_SEL_W;
  localparam int unsigned RGB_W   = 3 * COLOR_W;

  logic [PAL_SEL_W-1:0] r_active_pal;
  logic [PAL_SEL_W-1:0] w_eff_bank;
  logic [RGB_W-1:0]     w_bank_rgb [NUM_PAL];
  logic [RGB_W-1:0]     w_lookup;
  logic                 w_is_key;

  logic                 r_s1_valid;
  logic [RGB_W-1:0]     r_s1_rgb;
  logic                 r_s1_transp;

  assign w_eff_bank = frame_start_i ? pal_sel_i : r_active_pal;
  assign w_lookup   = w_bank_rgb[w_eff_bank];
  assign w_is_key   = (pix_index_i == INDEX_W'(TRANSP_INDEX));

  for (genvar b = 0; b < NUM_PAL; b++) begin : g_bank
    logic w_wr;
    assign w_wr = wr_en_i && (wr_pal_i == PAL_SEL_W'(b));

    palette_bank_ram #(
      .INDEX_W (INDEX_W),
      .COLOR_W (COLOR_W)
    ) u_bank (
      .i_clk      (Clk),
      .i_rst_n    (Reset_n),
      .i_wr_en    (w_wr),
      .i_wr_index (wr_index_i),
      .i_wr_rgb   (wr_rgb_i),
      .i_rd_index (pix_index_i),
      .o_rd_rgb   (w_bank_rgb[b])
    );
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_active_pal <= '0;
    end else if (frame_start_i) begin
      r_active_pal <= pal_sel_i;
    end
  end

  // Invalid cycles register zero colour so blanking needs no output gating
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_transp <= 1'b0;
    end else begin
      r_s1_valid  <= pix_valid_i;
      r_s1_rgb    <= pix_valid_i ? w_lookup : '0;
      r_s1_transp <= pix_valid_i && w_is_key;
    end
  end

  assign active_pal_o = r_active_pal;

`ifdef PAL_FADE_EN
  logic [COLOR_W-1:0] r_s1_fade;
  logic               r_s2_valid;
  logic [RGB_W-1:0]   r_s2_rgb;
  logic               r_s2_transp;

  function automatic logic [COLOR_W-1:0] sat_sub(input logic [COLOR_W-1:0] ch,
                                                  input logic [COLOR_W-1:0] f);
    return (ch > f) ? (ch - f) : '0;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_s1_fade   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_rgb    <= '0;
      r_s2_transp <= 1'b0;
    end else begin
      r_s1_fade   <= fade_i;
      r_s2_valid  <= r_s1_valid;
      r_s2_rgb    <= {sat_sub(r_s1_rgb[RGB_W-1 -: COLOR_W], r_s1_fade),
                      sat_sub(r_s1_rgb[2*COLOR_W-1 -: COLOR_W], r_s1_fade),
                      sat_sub(r_s1_rgb[COLOR_W-1:0], r_s1_fade)};
      r_s2_transp <= r_s1_transp;
    end
  end

  assign pix_valid_o   = r_s2_valid;
  assign transparent_o = r_s2_transp;
  assign red_o         = r_s2_rgb[RGB_W-1 -: COLOR_W];
  assign green_o       = r_s2_rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue_o        = r_s2_rgb[COLOR_W-1:0];
`else
  assign pix_valid_o   = r_s1_valid;
  assign transparent_o = r_s1_transp;
  assign red_o         = r_s1_rgb[RGB_W-1 -: COLOR_W];
  assign green_o       = r_s1_rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue_o        = r_s1_rgb[COLOR_W-1:0];
`endif

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Scoreboard bench for sprite_palette_lut: driver pushes expected pixels from
// a bank/array model, monitor pops on pix_valid_o. Honours PAL_FADE_EN.
module tb_sprite_palette_lut;

`ifdef PAL_FADE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [3:0]  pix_index_i = '0;
  logic        frame_start_i = 1'b0;
  logic [1:0]  pal_sel_i = '0;
  logic        wr_en_i = 1'b0;
  logic [1:0]  wr_pal_i = '0;
  logic [3:0]  wr_index_i = '0;
  logic [11:0] wr_rgb_i = '0;
  logic [3:0]  fade_v = '0;
  logic        pix_valid_o;
  logic [3:0]  red_o, green_o, blue_o;
  logic        transparent_o;
  logic [1:0]  active_pal_o;

  sprite_palette_lut dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .pix_valid_i   (pix_valid_i),
    .pix_index_i   (pix_index_i),
    .frame_start_i (frame_start_i),
    .pal_sel_i     (pal_sel_i),
    .wr_en_i       (wr_en_i),
    .wr_pal_i      (wr_pal_i),
    .wr_index_i    (wr_index_i),
    .wr_rgb_i      (wr_rgb_i),
    .pix_valid_o   (pix_valid_o),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .transparent_o (transparent_o),
    .active_pal_o  (active_pal_o)
`ifdef PAL_FADE_EN
    ,
    .fade_i        (fade_v)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned out_cyc;
    logic [11:0] rgb;
    logic        transp;
  } exp_t;

  exp_t        q[$];
  logic [11:0] m_pal [4][16];
  int unsigned m_active = 0;
  int unsigned cyc = 0;
  bit          chk_en = 0;
  int          checks = 0;
  int          failures = 0;

  logic [11:0] DEF [16] = '{12'h814, 12'hF0F, 12'hECA, 12'h115, 12'hC1A, 12'hB75,
                            12'hA01, 12'h621, 12'h229, 12'hA18, 12'h002, 12'h425,
                            12'hE1D, 12'h843, 12'hD33, 12'hD97};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++) m_pal[b][i] = DEF[i];
    m_active = 0;
  endtask

  function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] f);
    int v;
    v = int'(c) - int'(f);
    return (v < 0) ? 4'h0 : 4'(v);
  endfunction

  task automatic cycle(input logic v, input logic [3:0] idx, input logic fs,
                       input logic [1:0] sel, input logic we, input logic [1:0] wp,
                       input logic [3:0] wi, input logic [11:0] wd, input logic [3:0] fd);
    int unsigned eff;
    logic [11:0] col;
    logic [3:0]  f;
    exp_t        e;
    @(negedge Clk);
    Reset_n = 1'b1;
    pix_valid_i = v; pix_index_i = idx; frame_start_i = fs; pal_sel_i = sel;
    wr_en_i = we; wr_pal_i = wp; wr_index_i = wi; wr_rgb_i = wd; fade_v = fd;
    eff = fs ? int'(sel) : m_active;
    if (v) begin
      col = (we && int'(wp) == eff && wi == idx) ? wd : m_pal[eff][idx];
      f = (LAT == 2) ? fd : 4'h0;
      e.out_cyc = cyc + LAT;
      e.rgb = {fade_ch(col[11:8], f), fade_ch(col[7:4], f), fade_ch(col[3:0], f)};
      e.transp = (idx == 4'd1);
      q.push_back(e);
    end
    if (we) m_pal[wp][wi] = wd;
    if (fs) m_active = sel;
  endtask

  // Reset cycle with busy inputs: in-flight pixels and the pending write are lost
  task automatic reset_cycle();
    @(negedge Clk);
    Reset_n = 1'b0;
    pix_valid_i = 1'b1; pix_index_i = 4'($urandom); frame_start_i = 1'b1;
    pal_sel_i = 2'($urandom); wr_en_i = 1'b1; wr_pal_i = 2'($urandom);
    wr_index_i = 4'($urandom); wr_rgb_i = 12'($urandom);
    while (q.size() > 0 && q[$].out_cyc >= cyc + 1) void'(q.pop_back());
    model_reset();
    chk_en = 1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 12'h000, 4'h0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      if (chk_en) begin
        chk("active_pal", 32'(active_pal_o), 32'(m_active));
        if (pix_valid_o) begin
          if (q.size() == 0 || q[0].out_cyc != cyc) begin
            chk("unexpected_valid", 32'(pix_valid_o), 32'(0));
          end else begin
            e = q.pop_front();
            chk("rgb", 32'({red_o, green_o, blue_o}), 32'(e.rgb));
            chk("transparent", 32'(transparent_o), 32'(e.transp));
          end
        end else begin
          chk("blank_out", 32'({red_o, green_o, blue_o, transparent_o}), 32'(0));
          if (q.size() > 0 && q[0].out_cyc == cyc) begin
            chk("missing_valid", 32'(pix_valid_o), 32'(1));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    reset_cycle();
    reset_cycle();
    // Default colours and key flag
    cycle(1, 0, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    cycle(1, 1, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    idle();
    // Write inactive bank 2, then switch to it at frame start
    cycle(0, 0, 0, 0, 1, 2, 3, 12'h0F0, 4'h0);
    cycle(1, 3, 1, 2, 0, 0, 0, 12'h000, 4'h0);
    cycle(1, 3, 0, 2, 0, 0, 0, 12'h000, 4'h0);
    // Mid-frame select change is ignored
    cycle(1, 3, 0, 1, 0, 0, 0, 12'h000, 4'h0);
    cycle(1, 0, 0, 1, 1, 0, 0, 12'hABC, 4'h0);
    cycle(1, 0, 1, 1, 0, 0, 0, 12'h000, 4'h0);
    // Same-cycle write/lookup forwarding on bank 0
    cycle(1, 5, 1, 0, 1, 0, 5, 12'h123, 4'h0);
    cycle(1, 5, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    // Valid toggling
    cycle(1, 2, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    cycle(0, 2, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    cycle(1, 2, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    // Fade (no effect without PAL_FADE_EN)
    cycle(1, 2, 0, 0, 0, 0, 0, 12'h000, 4'h4);
    cycle(1, 2, 0, 0, 0, 0, 0, 12'h000, 4'hF);
    cycle(1, 1, 0, 0, 0, 0, 0, 12'h000, 4'h3);
    // Reset mid-stream, then confirm bank 0 index 5 is back to default
    cycle(1, 5, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    reset_cycle();
    cycle(1, 5, 0, 0, 0, 0, 0, 12'h000, 4'h0);
    cycle(1, 3, 1, 2, 0, 0, 0, 12'h000, 4'h0);
    idle();
    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_cycle();
      end else begin
        cycle(($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 19) == 0),
              2'($urandom), ($urandom_range(0, 4) == 0), 2'($urandom),
              4'($urandom), 12'($urandom), 4'($urandom));
      end
    end
    for (int n = 0; n < 4; n++) idle();
    @(negedge Clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
